// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: FP32 width, PE beat-count
// width, feeder FSM state encoding and the PE header beat format.
package nn_pkg;

  localparam int FP_W       = 32;
  localparam int PE_CNT_W   = 10;
  localparam int HEAD_PAD_W = FP_W - PE_CNT_W;

  // Feeder FSM encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_HEAD   = 3'd2;
  localparam state_t ST_STREAM = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;
  localparam state_t ST_FIN    = 3'd5;

  // Header beat: beat count in the low bits, zero-padded above.
  function automatic logic [FP_W-1:0] head_beat(input logic [PE_CNT_W-1:0] cnt);
    return {{HEAD_PAD_W{1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/pe_stream_feeder.sv
// Initiator side of the PE operand stream. For each neuron: fetch the bias,
// send one header beat, stream N_IN weight/input pairs back to back, then
// capture the PE result a fixed PE_LAT cycles after the last beat. The PE's
// done level is only checked for sanity, never used for sequencing.
module pe_stream_feeder
  import nn_pkg::*;
#(
  parameter int N_IN     = 784,
  parameter int N_NEURON = 10,
  parameter int PE_LAT   = 2,
  parameter int WA = (N_IN * N_NEURON > 1) ? $clog2(N_IN * N_NEURON) : 1,
  parameter int XA = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int NA = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [WA-1:0]       w_addr,
  input  logic [FP_W-1:0]     w_data,
  output logic [XA-1:0]       x_addr,
  input  logic [FP_W-1:0]     x_data,
  output logic [NA-1:0]       b_addr,
  input  logic [FP_W-1:0]     b_data,
  output logic                pe_head,
  output logic [FP_W-1:0]     pe_x,
  output logic [FP_W-1:0]     pe_w,
  output logic [FP_W-1:0]     pe_b,
  output logic [PE_CNT_W-1:0] pe_count,
  input  logic [FP_W-1:0]     pe_out,
  input  logic                pe_done,
  output logic                res_valid,
  output logic [NA-1:0]       res_idx,
  output logic [FP_W-1:0]     res_data,
  output logic                err_nodone
);

  localparam logic [XA-1:0]       X_LAST = XA'(N_IN - 1);
  localparam logic [WA-1:0]       W_STEP = WA'(N_IN);
  localparam logic [NA-1:0]       N_LAST = NA'(N_NEURON - 1);
  localparam logic [PE_CNT_W-1:0] K_LAST = PE_CNT_W'(N_IN - 1);
  localparam logic [2:0]          L_LAST = 3'(PE_LAT - 1);

  state_t              state_q, state_d;
  logic [NA-1:0]       n_q, n_d;
  logic [PE_CNT_W-1:0] k_q, k_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [WA-1:0]       base_q, base_d;
  logic [WA-1:0]       w_addr_q, w_addr_d;
  logic [XA-1:0]       x_addr_q, x_addr_d;
  logic [NA-1:0]       b_addr_q, b_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                res_valid_q, res_valid_d;
  logic [NA-1:0]       res_idx_q, res_idx_d;
  logic [FP_W-1:0]     res_data_q, res_data_d;
  logic                err_q, err_d;

  // Next-state, address sequencing and result capture.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    wcnt_d      = wcnt_q;
    base_d      = base_q;
    w_addr_d    = w_addr_q;
    x_addr_d    = x_addr_q;
    b_addr_d    = b_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          n_d      = {NA{1'b0}};
          base_d   = {WA{1'b0}};
          b_addr_d = {NA{1'b0}};
          busy_d   = 1'b1;
          err_d    = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Present beat 0 addresses during the header so data lines up with beat 0.
        state_d  = ST_HEAD;
        w_addr_d = base_q;
        x_addr_d = {XA{1'b0}};
        k_d      = {PE_CNT_W{1'b0}};
      end
      ST_HEAD: begin
        state_d = ST_STREAM;
        if (x_addr_q != X_LAST) begin
          w_addr_d = w_addr_q + WA'(1);
          x_addr_d = x_addr_q + XA'(1);
        end else begin
          w_addr_d = w_addr_q;
          x_addr_d = x_addr_q;
        end
      end
      ST_STREAM: begin
        // Prefetch the next beat; past the last beat the addresses hold.
        if (x_addr_q != X_LAST) begin
          w_addr_d = w_addr_q + WA'(1);
          x_addr_d = x_addr_q + XA'(1);
        end else begin
          w_addr_d = w_addr_q;
          x_addr_d = x_addr_q;
        end
        if (k_q == K_LAST) begin
          state_d = ST_WAIT;
          wcnt_d  = 3'd0;
        end else begin
          k_d     = k_q + PE_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (wcnt_q == L_LAST) begin
          res_valid_d = 1'b1;
          res_idx_d   = n_q;
          res_data_d  = pe_out;
          err_d       = err_q | ~pe_done;
          if (n_q == N_LAST) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            n_d      = n_q + NA'(1);
            b_addr_d = n_q + NA'(1);
            base_d   = base_q + W_STEP;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // PE beat formatting: header carries count and bias, data beats carry RAM data.
  always_comb begin
    pe_head  = 1'b0;
    pe_x     = {FP_W{1'b0}};
    pe_w     = {FP_W{1'b0}};
    pe_b     = {FP_W{1'b0}};
    pe_count = {PE_CNT_W{1'b0}};
    case (state_q)
      ST_HEAD: begin
        pe_head = 1'b1;
        pe_x    = head_beat(PE_CNT_W'(N_IN));
        pe_b    = b_data;
      end
      ST_STREAM: begin
        pe_w     = w_data;
        pe_x     = x_data;
        pe_count = k_q;
      end
      default: begin
        pe_head = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops everything, including any pending result.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= {NA{1'b0}};
      k_q         <= {PE_CNT_W{1'b0}};
      wcnt_q      <= 3'd0;
      base_q      <= {WA{1'b0}};
      w_addr_q    <= {WA{1'b0}};
      x_addr_q    <= {XA{1'b0}};
      b_addr_q    <= {NA{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= {NA{1'b0}};
      res_data_q  <= {FP_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wcnt_q      <= wcnt_d;
      base_q      <= base_d;
      w_addr_q    <= w_addr_d;
      x_addr_q    <= x_addr_d;
      b_addr_q    <= b_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign w_addr     = w_addr_q;
  assign x_addr     = x_addr_q;
  assign b_addr     = b_addr_q;
  assign res_valid  = res_valid_q;
  assign res_idx    = res_idx_q;
  assign res_data   = res_data_q;
  assign err_nodone = err_q;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder. Instance A (N_IN=3) drives a behavioural FP32
// dot-product PE and is checked through a result scoreboard; instance B
// (N_IN=4) feeds address-tagged RAM data and its PE beats are checked directly.
module tb_pe_stream_feeder;

  localparam int WA_A = 3, XA_A = 2, NA_A = 1;
  localparam int WA_B = 3, XA_B = 2, NA_B = 1;

  localparam logic [31:0] F_ONE  = 32'h3F800000;
  localparam logic [31:0] F_MONE = 32'hBF800000;
  localparam logic [31:0] F_TWO  = 32'h40000000;
  localparam logic [31:0] F_HALF = 32'h3F000000;
  localparam logic [31:0] F_6P5  = 32'h40D00000;
  localparam logic [31:0] F_M5P5 = 32'hC0B00000;

  logic clock = 1'b0;
  logic rst_n, start_a, start_b, hold_nodone;

  logic            busy_a, done_a, pe_head_a, pe_done_a, res_valid_a, err_a;
  logic [WA_A-1:0] w_addr_a;
  logic [XA_A-1:0] x_addr_a;
  logic [NA_A-1:0] b_addr_a, res_idx_a;
  logic [31:0]     w_data_a, x_data_a, b_data_a, pe_x_a, pe_w_a, pe_b_a, pe_out_a, res_data_a;
  logic [9:0]      pe_count_a;

  logic            busy_b, done_b, pe_head_b, res_valid_b, err_b;
  logic [WA_B-1:0] w_addr_b;
  logic [XA_B-1:0] x_addr_b;
  logic [NA_B-1:0] b_addr_b, res_idx_b;
  logic [31:0]     w_data_b, x_data_b, b_data_b, pe_x_b, pe_w_b, pe_b_b, res_data_b;
  logic [9:0]      pe_count_b;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed { logic [31:0] idx; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  logic [31:0] w_mem [0:7];
  logic [31:0] x_mem [0:3];
  logic [31:0] b_mem [0:1];

  always #5 clock = ~clock;

  pe_stream_feeder #(.N_IN(3), .N_NEURON(2), .PE_LAT(2), .WA(WA_A), .XA(XA_A), .NA(NA_A)) dut_a (
    .clock(clock), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .w_addr(w_addr_a), .w_data(w_data_a), .x_addr(x_addr_a), .x_data(x_data_a),
    .b_addr(b_addr_a), .b_data(b_data_a), .pe_head(pe_head_a), .pe_x(pe_x_a),
    .pe_w(pe_w_a), .pe_b(pe_b_a), .pe_count(pe_count_a), .pe_out(pe_out_a),
    .pe_done(pe_done_a), .res_valid(res_valid_a), .res_idx(res_idx_a),
    .res_data(res_data_a), .err_nodone(err_a));

  pe_stream_feeder #(.N_IN(4), .N_NEURON(2), .PE_LAT(2), .WA(WA_B), .XA(XA_B), .NA(NA_B)) dut_b (
    .clock(clock), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .x_addr(x_addr_b), .x_data(x_data_b),
    .b_addr(b_addr_b), .b_data(b_data_b), .pe_head(pe_head_b), .pe_x(pe_x_b),
    .pe_w(pe_w_b), .pe_b(pe_b_b), .pe_count(pe_count_b), .pe_out(32'd0),
    .pe_done(1'b1), .res_valid(res_valid_b), .res_idx(res_idx_b),
    .res_data(res_data_b), .err_nodone(err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // 1-cycle-latency RAMs: real contents for A, address-tagged data for B.
  always @(posedge clock) begin
    w_data_a <= w_mem[w_addr_a];
    x_data_a <= x_mem[x_addr_a];
    b_data_a <= b_mem[b_addr_a];
    w_data_b <= 32'h1000 + 32'(w_addr_b);
    x_data_b <= 32'h2000 + 32'(x_addr_b);
    b_data_b <= 32'h3000 + 32'(b_addr_b);
  end

  // Behavioural PE: bias on header, multiply-accumulate on the following beats.
  real acc;
  int  remain;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 0.0; remain <= 0; pe_out_a <= 32'd0; pe_done_a <= 1'b0;
    end else begin
      if (pe_head_a) begin
        acc <= f2r(pe_b_a);
        remain <= int'(pe_x_a[9:0]);
      end else if (remain > 0) begin
        acc <= acc + f2r(pe_w_a) * f2r(pe_x_a);
        remain <= remain - 1;
        if (remain == 1) begin
          pe_out_a <= r2f(acc + f2r(pe_w_a) * f2r(pe_x_a));
          pe_done_a <= 1'b1;
        end
      end
      if (hold_nodone) pe_done_a <= 1'b0;
    end
  end

  // Scoreboard monitor for instance A results.
  always @(negedge clock) begin : mon_a
    exp_t e;
    if (res_valid_a) begin
      if (sb_q.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("res_idx", 32'(res_idx_a), e.idx);
        chk("res_data", res_data_a, e.data);
      end
    end
  end

  // Protocol monitor for instance B beats and results.
  int heads_b = 0, beat_b = 0, nb = 0, resb = 0;
  logic in_b = 1'b0;
  always @(negedge clock) begin
    if (pe_head_b) begin
      chk("b_head_contig", 32'(in_b), 32'd0);
      chk("b_head_x", pe_x_b, 32'h00000004);
      chk("b_head_b", pe_b_b, 32'h3000 + 32'(nb));
      chk("b_head_waddr", 32'(w_addr_b), 32'(nb * 4));
      chk("b_head_xaddr", 32'(x_addr_b), 32'd0);
      heads_b++; in_b = 1'b1; beat_b = 0;
    end else if (in_b) begin
      chk("b_count", 32'(pe_count_b), 32'(beat_b));
      chk("b_w", pe_w_b, 32'h1000 + 32'(nb * 4 + beat_b));
      chk("b_x", pe_x_b, 32'h2000 + 32'(beat_b));
      chk("b_waddr", 32'(w_addr_b), 32'(nb * 4 + ((beat_b + 1 > 3) ? 3 : beat_b + 1)));
      chk("b_xaddr", 32'(x_addr_b), 32'((beat_b + 1 > 3) ? 3 : beat_b + 1));
      beat_b++;
      if (beat_b == 4) begin in_b = 1'b0; nb++; end
    end
    if (res_valid_b) begin
      chk("b_res_idx", 32'(res_idx_b), 32'(resb));
      chk("b_res_data", res_data_b, 32'd0);
      resb++;
    end
  end

  // One layer on A: push expectations, start, optionally re-pulse start at cycle pulse_at.
  task automatic run_a(input logic [31:0] e0, input logic [31:0] e1, input logic exp_err, input int pulse_at);
    int cyc;
    logic seen;
    seen = 1'b0;
    sb_q.push_back('{32'd0, e0});
    sb_q.push_back('{32'd1, e1});
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0; cyc = 1;
    chk("busy_after_start", 32'(busy_a), 32'd1);
    chk("err_cleared_on_start", 32'(err_a), 32'd0);
    while (!done_a && cyc < 200) begin
      @(negedge clock); cyc++;
      start_a = (cyc == pulse_at);
      if (res_valid_a && !seen) begin
        seen = 1'b1;
        chk("err_first_capture", 32'(err_a), 32'(exp_err));
      end
    end
    chk("done_latency", 32'(cyc), 32'd15);
    chk("busy_in_fin", 32'(busy_a), 32'd1);
    chk("err_at_done", 32'(err_a), 32'(exp_err));
    @(negedge clock); start_a = 1'b0;
    chk("busy_after_done", 32'(busy_a), 32'd0);
    chk("done_pulse_width", 32'(done_a), 32'd0);
    repeat (4) @(negedge clock);
    chk("stays_idle", 32'(busy_a), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; hold_nodone = 1'b0;
    for (int i = 0; i < 8; i++) w_mem[i] = F_ONE;
    for (int i = 0; i < 4; i++) x_mem[i] = F_TWO;
    b_mem[0] = F_HALF; b_mem[1] = F_HALF;

    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_res_valid", 32'(res_valid_a), 32'd0);
    chk("rst_res_data", res_data_a, 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_addrs", {26'd0, w_addr_a, x_addr_a, b_addr_a}, 32'd0);
    chk("rst_pe", pe_x_a | pe_w_a | pe_b_a | {21'd0, pe_head_a, pe_count_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    // Protocol run on B.
    start_b = 1'b1; @(negedge clock); start_b = 1'b0; cyc = 1;
    while (!done_b && cyc < 200) begin @(negedge clock); cyc++; end
    chk("b_done_latency", 32'(cyc), 32'd17);
    repeat (2) @(negedge clock);
    chk("b_heads", 32'(heads_b), 32'd2);
    chk("b_results", 32'(resb), 32'd2);
    chk("b_err", 32'(err_b), 32'd0);
    chk("b_idle", 32'(busy_b), 32'd0);

    // Uniform weights, then negative weights on neuron 1.
    run_a(F_6P5, F_6P5, 1'b0, 0);
    for (int i = 3; i < 6; i++) w_mem[i] = F_MONE;
    run_a(F_6P5, F_M5P5, 1'b0, 0);
    // start while busy, then start during FIN; both ignored.
    run_a(F_6P5, F_M5P5, 1'b0, 5);
    run_a(F_6P5, F_M5P5, 1'b0, 15);
    run_a(F_6P5, F_M5P5, 1'b0, 0);

    // Reset during neuron 0 streaming.
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b0; #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_pe", pe_x_a | pe_w_a | {21'd0, pe_head_a, pe_count_a}, 32'd0);
    chk("midrst_addrs", {26'd0, w_addr_a, x_addr_a, b_addr_a}, 32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("midrst_idle", 32'(busy_a), 32'd0);
    chk("midrst_no_result", 32'(res_data_a), 32'd0);
    run_a(F_6P5, F_M5P5, 1'b0, 0);

    // PE never raises done: error flag set, results still emitted, then cleared.
    hold_nodone = 1'b1;
    run_a(F_6P5, F_M5P5, 1'b1, 0);
    hold_nodone = 1'b0;
    run_a(F_6P5, F_M5P5, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
Initiator side of the processing-element (PE) operand stream. On start, for each neuron in turn: fetch bias, issue the PE header beat, stream N_IN weight/input pairs, then capture the PE result at a fixed latency and emit it on a result port. Sits between the weight/input/bias RAMs and one pro_ele instance; a layer controller drives start and collects results.

Parameters:
N_IN, 784, inputs per neuron = beats per header; legal range 1..1023 (must fit the 10-bit PE count).
N_NEURON, 10, neurons processed per start.
PE_LAT, 2, cycles from the last data beat to a valid pe_out; legal range 2..7.
WA, clog2(N_IN*N_NEURON), weight address width.
XA, clog2(N_IN), input address width.
NA, clog2(N_NEURON), bias address and result index width.

Ports:
clock  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin layer; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last result
w_addr  out  WA  weight RAM address; RAM read latency is 1 cycle
w_data  in  32  FP32 weight
x_addr  out  XA  input RAM address; 1-cycle latency
x_data  in  32  FP32 input
b_addr  out  NA  bias RAM address; 1-cycle latency
b_data  in  32  FP32 bias
pe_head  out  1  PE header strobe
pe_x  out  32  header beat: {22'b0, N_IN[9:0]}; data beat: x_data
pe_w  out  32  data beat: w_data; otherwise 0
pe_b  out  32  b_data on the header beat; otherwise 0
pe_count  out  10  beat index on data beats; otherwise 0
pe_out  in  32  PE result
pe_done  in  1  PE done level; this is a sticky level, not a pulse
res_valid  out  1  one-cycle result strobe
res_idx  out  NA  neuron index of res_data
res_data  out  32  captured pe_out
err_nodone  out  1  sticky; set if pe_done is low at capture; cleared on start

Behaviour:
- Reset: state=IDLE. All outputs 0, including addresses, busy, done, res_*, and err_nodone.
- FSM states: IDLE -> LOAD -> HEAD -> STREAM -> WAIT -> (LOAD | FIN) -> IDLE.
- IDLE: start=1 -> LOAD, with n=0, busy=1, err_nodone=0.
- LOAD, 1 cycle: b_addr=n.
- HEAD, 1 cycle:
  - pe_head=1, pe_b=b_data, pe_x={22'b0, N_IN}.
  - w_addr=n*N_IN, x_addr=0, k=0.
- STREAM, N_IN cycles, k=0..N_IN-1:
  - pe_w=w_data, pe_x=x_data, pe_count=k, pe_head=0.
  - Issue addresses for beat k+1: w_addr=n*N_IN+k+1, x_addr=k+1.
  - The address past the last beat is don't-care but must not exceed range; hold the last address.
  - The last beat is k=N_IN-1; then go to WAIT.
- WAIT, PE_LAT cycles, pe_* driven 0:
  - On the clock edge ending the final WAIT cycle: res_data<=pe_out, res_idx<=n, res_valid<=1 (high for the next cycle only).
  - At the same edge, if pe_done=0, set err_nodone.
  - Next state: if n==N_NEURON-1 go to FIN, else n<=n+1 and go to LOAD.
- The res_valid pulse overlaps the next LOAD.
- FIN, 1 cycle: done=1, busy=0 at the next edge, then IDLE.
- pe_done is never used for sequencing. The PE's done level is not cleared between neurons, so capture timing is fixed by PE_LAT.
- Cycles per neuron: N_IN+PE_LAT+2. Total latency from start to done pulse: N_NEURON*(N_IN+PE_LAT+2)+1 cycles.
- n*N_IN is computed with an incrementing base register (add N_IN per neuron), not a multiplier.
- start while busy: ignored. start in the FIN cycle: ignored.
- rst_n asserted mid-operation: immediate return to IDLE and all outputs 0. No partial result is emitted.
- Exactly one pe_head per neuron, immediately followed by N_IN contiguous data beats with no bubbles.

Decomposition:
- Shared package nn_pkg holds:
  - FP32 width localparam (32).
  - PE count width (10).
  - FSM state encoding typedef.
  - Header beat format constant (count in bits [9:0]).
- No sub-module is needed. A separate pe_result_capture sub-module is optional if the WAIT/result logic is reused.

Test Plan:
- Config for the first two tests: N_IN=3, N_NEURON=2, PE_LAT=2, bench uses a real pro_ele.
  - All w=0x3F800000 (1.0), x=0x40000000 (2.0), b=0x3F000000 (0.5) -> two res_valid pulses, idx 0 then 1, each res_data=0x40D00000 (6.5); done 15 cycles after start; err_nodone=0.
  - Neuron 1 weights = 0xBF800000 (-1.0) -> res_data idx1 = 0xC0B00000 (-5.5); idx0 unchanged at 6.5.
- Protocol check, N_IN=4: exactly one pe_head per neuron, with pe_x=0x00000004 and pe_b=bias; pe_head is followed by 4 contiguous beats with pe_count 0,1,2,3 and the correct w_addr/x_addr sequence.
- start re-pulsed while busy -> no restart, same result sequence. start in IDLE after done -> second full run with identical results.
- rst_n low during STREAM of neuron 0 -> outputs 0 immediately, no res_valid. A fresh start then gives correct results.
- Bench PE model that holds pe_done=0 -> err_nodone=1 after the first capture; results still emitted; err_nodone cleared by the next start.
